// File: rtl/cordic_pkg.sv
// cordic_pkg: shared types and constants for the iterative CORDIC sequencer.
// Holds the default sizing, the FSM state encoding, the arctangent table
// (binary angle units, 2^(WIDTH-1) = pi, built for WIDTH=9) and the shift
// amounts of the optional gain correction (enabled by CORDIC_GAIN_COMP_EN).
package cordic_pkg;
   localparam int WIDTH_DEF = 9;
   localparam int ITER_DEF  = 8;
   localparam int CNT_W_DEF = 4;
   typedef enum logic [1:0] {IDLE, RUN, COMP, DONE} state_t;
   localparam int ATAN_N = 8;
   localparam int ATAN [ATAN_N] = '{64, 38, 20, 10, 5, 3, 1, 1};
   localparam int GC_SH0 = 1;
   localparam int GC_SH1 = 3;
   localparam int GC_SH2 = 6;
   localparam int GC_SH3 = 9;
   // Indices past the table read as zero so a wide counter can never select garbage.
   function automatic int atan_lut(input int i);
      return (i >= 0 && i < ATAN_N) ? ATAN[i] : 0;
   endfunction
endpackage

// File: rtl/cordic_iter.sv
// cordic_iter: one combinational rotation-mode CORDIC micro-rotation.
// Ports:
//   x, y, z                 current vector and residual angle (two's complement)
//   i                       iteration index (shift amount and ATAN selector)
//   x_nxt, y_nxt, z_nxt     rotated vector and updated residual angle
// Direction comes from the sign of z; all sums wrap modulo 2^WIDTH.
module cordic_iter
   import cordic_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic signed [WIDTH-1:0] x,
   input  logic signed [WIDTH-1:0] y,
   input  logic signed [WIDTH-1:0] z,
   input  logic        [CNT_W-1:0] i,
   output logic signed [WIDTH-1:0] x_nxt,
   output logic signed [WIDTH-1:0] y_nxt,
   output logic signed [WIDTH-1:0] z_nxt
);
   logic signed [WIDTH-1:0] xs, ys, a;
   logic neg;
   always_comb begin
      neg   = z[WIDTH-1];
      xs    = x >>> i;
      ys    = y >>> i;
      a     = WIDTH'(atan_lut(int'(i)));
      x_nxt = neg ? x + ys : x - ys;
      y_nxt = neg ? y - xs : y + xs;
      z_nxt = neg ? z + a : z - a;
   end
endmodule

// File: rtl/cordic_seq_ctrl.sv
// cordic_seq_ctrl: iterative rotation-mode CORDIC sequencer, one micro-rotation per clock.
// Ports:
//   clock                 rising-edge clock
//   reset                 asynchronous active-low reset
//   start                 job request, sampled only while ready=1
//   x_in, y_in, z_in      initial vector and target angle (2^(WIDTH-1) = pi)
//   ready                 high in IDLE only
//   done                  one-cycle pulse when x_out/y_out/z_out are fresh
//   x_out, y_out, z_out   result, held until the next job completes
// Macro CORDIC_GAIN_COMP_EN inserts a COMP state that scales x/y by ~0.6074.
module cordic_seq_ctrl
   import cordic_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int ITER  = ITER_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] x_in,
   input  logic signed [WIDTH-1:0] y_in,
   input  logic signed [WIDTH-1:0] z_in,
   output logic                    ready,
   output logic                    done,
   output logic signed [WIDTH-1:0] x_out,
   output logic signed [WIDTH-1:0] y_out,
   output logic signed [WIDTH-1:0] z_out
);
`ifdef CORDIC_GAIN_COMP_EN
   localparam state_t AFTER_RUN = COMP;
   function automatic logic signed [WIDTH-1:0] gain_comp(input logic signed [WIDTH-1:0] v);
      return (v >>> GC_SH0) + (v >>> GC_SH1) - (v >>> GC_SH2) - (v >>> GC_SH3);
   endfunction
`else
   localparam state_t AFTER_RUN = DONE;
`endif
   state_t state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic signed [WIDTH-1:0] x_r, y_r, z_r, x_n, y_n, z_n;
   logic last;

   cordic_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
      .x(x_r), .y(y_r), .z(z_r), .i(cnt),
      .x_nxt(x_n), .y_nxt(y_n), .z_nxt(z_n)
   );

   always_ff @(posedge clock or negedge reset)
      if (!reset) state <= IDLE;
      else        state <= state_nxt;

   always_comb begin
      state_nxt = state;
      last      = cnt == CNT_W'(ITER - 1);
      case (state)
         IDLE:    state_nxt = start ? RUN : IDLE;
         RUN:     state_nxt = last ? AFTER_RUN : RUN;
         COMP:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
      ready = state == IDLE;
      done  = state == DONE;
   end

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         cnt   <= '0;
         x_r   <= '0;
         y_r   <= '0;
         z_r   <= '0;
         x_out <= '0;
         y_out <= '0;
         z_out <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               x_r <= x_in;
               y_r <= y_in;
               z_r <= z_in;
               cnt <= '0;
            end
            RUN: begin
               x_r <= x_n;
               y_r <= y_n;
               z_r <= z_n;
               cnt <= cnt + CNT_W'(1);
`ifndef CORDIC_GAIN_COMP_EN
               // Without correction the last rotation feeds the outputs directly.
               if (last) begin
                  x_out <= x_n;
                  y_out <= y_n;
                  z_out <= z_n;
               end
`endif
            end
`ifdef CORDIC_GAIN_COMP_EN
            COMP: begin
               x_out <= gain_comp(x_r);
               y_out <= gain_comp(y_r);
               z_out <= z_r;
            end
`endif
            default: ;
         endcase
      end
endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// tb_cordic_seq_ctrl: directed, scoreboard-based bench for cordic_seq_ctrl (ITER=8 and ITER=1).
module tb_cordic_seq_ctrl;
   localparam int ITER  = 8;
   localparam int ITER1 = 1;
`ifdef CORDIC_GAIN_COMP_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif
   localparam int LAT  = ITER + 1 + EXTRA;
   localparam int LAT1 = ITER1 + 1 + EXTRA;
   localparam int TBL [8] = '{64, 38, 20, 10, 5, 3, 1, 1};

   typedef struct {
      int x;
      int y;
      int z;
   } res_t;

   logic clock = 0;
   logic reset = 1;
   logic start = 0, start1 = 0;
   logic signed [8:0] x_in = 0, y_in = 0, z_in = 0;
   logic ready, done, ready1, done1;
   logic signed [8:0] x_out, y_out, z_out, x_out1, y_out1, z_out1;

   int checks = 0, failures = 0, done_cnt = 0, cyc = 0;
   res_t sb[$];

   cordic_seq_ctrl #(.WIDTH(9), .ITER(ITER), .CNT_W(4)) dut (
      .clock(clock), .reset(reset), .start(start),
      .x_in(x_in), .y_in(y_in), .z_in(z_in),
      .ready(ready), .done(done),
      .x_out(x_out), .y_out(y_out), .z_out(z_out)
   );

   cordic_seq_ctrl #(.WIDTH(9), .ITER(ITER1), .CNT_W(1)) dut1 (
      .clock(clock), .reset(reset), .start(start1),
      .x_in(x_in), .y_in(y_in), .z_in(z_in),
      .ready(ready1), .done(done1),
      .x_out(x_out1), .y_out(y_out1), .z_out(z_out1)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;
   always @(negedge clock) if (done) done_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic int wr(input int v);
      return ((v & 511) ^ 256) - 256;
   endfunction

   function automatic res_t model(input int xi, input int yi, input int zi, input int iters);
      res_t r;
      int x, y, z, xn, yn;
      x = wr(xi);
      y = wr(yi);
      z = wr(zi);
      for (int i = 0; i < iters; i++) begin
         if (z < 0) begin
            xn = x + (y >>> i);
            yn = y - (x >>> i);
            z  = z + TBL[i];
         end else begin
            xn = x - (y >>> i);
            yn = y + (x >>> i);
            z  = z - TBL[i];
         end
         x = wr(xn);
         y = wr(yn);
         z = wr(z);
      end
      if (EXTRA != 0) begin
         x = wr((x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9));
         y = wr((y >>> 1) + (y >>> 3) - (y >>> 6) - (y >>> 9));
      end
      r.x = x;
      r.y = y;
      r.z = z;
      return r;
   endfunction

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input int x, input int y, input int z);
      start = 1;
      x_in  = 9'(x);
      y_in  = 9'(y);
      z_in  = 9'(z);
   endtask

   task automatic launch(input int x, input int y, input int z);
      drive(x, y, z);
      sb.push_back(model(x, y, z, ITER));
   endtask

   // Runs from the accepting edge to the done cycle, then pops and compares one result.
   task automatic wait_done(input string tag, input bit spam, input bit hold, input res_t hv,
                            output int at_cyc);
      int n, low;
      bit held_bad;
      res_t e;
      n = 0;
      low = 0;
      held_bad = 0;
      while (n < 60) begin
         tick();
         n++;
         if (!ready) low++;
         if (done) break;
         if (hold && (x_out !== 9'(hv.x) || y_out !== 9'(hv.y) || z_out !== 9'(hv.z))) held_bad = 1;
         if (spam) begin
            x_in = 9'($urandom_range(0, 511));
            y_in = 9'($urandom_range(0, 511));
            z_in = 9'($urandom_range(0, 511));
         end else start = 0;
      end
      start = 0;
      at_cyc = cyc;
      chk({tag, "_done_seen"}, done, 1);
      chk({tag, "_latency"}, n, LAT);
      chk({tag, "_ready_low"}, low, LAT);
      if (hold) chk({tag, "_held"}, held_bad, 0);
      chk({tag, "_sb_nonempty"}, sb.size() > 0, 1);
      if (done && sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_x"}, x_out, e.x);
         chk({tag, "_y"}, y_out, e.y);
         chk({tag, "_z"}, z_out, e.z);
         chk({tag, "_known"}, $isunknown({x_out, y_out, z_out}), 0);
      end
   endtask

   initial begin
      int t1, t2, dc0, n;
      res_t ra, m1, none;
      none = '{0, 0, 0};
      #2 reset = 0;
      #1;
      chk("rst_ready", ready, 1);
      chk("rst_done", done, 0);
      chk("rst_x", x_out, 0);
      chk("rst_y", y_out, 0);
      chk("rst_z", z_out, 0);
      chk("rst_ready1", ready1, 1);
      tick();
      tick();
      reset = 1;
      tick();

      drive(100, 0, 0);
      if (EXTRA != 0) sb.push_back('{100, 0, 0});
      else            sb.push_back('{165, 1, 0});
      wait_done("basic", 0, 0, none, t1);
      tick();
      chk("basic_ready_back", ready, 1);
      chk("basic_done_pulse", done, 0);
      chk("basic_hold_after", x_out, (EXTRA != 0) ? 100 : 165);

      dc0 = done_cnt;
      launch(50, -30, 40);
      wait_done("spam", 1, 0, none, t1);
      repeat (5) tick();
      chk("spam_ready", ready, 1);
      chk("spam_pulses", done_cnt - dc0, 1);

      launch(200, 200, 0);
      wait_done("wrap", 0, 0, none, t1);
      tick();

      for (int k = 0; k < 3; k++) begin
         launch(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
                int'($urandom_range(0, 511)) - 256);
         wait_done("rand", 0, 0, none, t1);
         tick();
      end

      ra = model(-120, 90, 100, ITER);
      launch(-120, 90, 100);
      wait_done("b2b_a", 0, 0, none, t1);
      tick();
      chk("b2b_ready", ready, 1);
      launch(100, 50, 0);
      wait_done("b2b_b", 0, 1, ra, t2);
      chk("b2b_gap", t2 - t1, LAT + 1);
      tick();

      drive(-70, 30, -90);
      tick();
      start = 0;
      tick();
      tick();
      chk("abort_running", ready, 0);
      #2 reset = 0;
      #1;
      chk("abort_ready", ready, 1);
      chk("abort_done", done, 0);
      chk("abort_x", x_out, 0);
      chk("abort_y", y_out, 0);
      chk("abort_z", z_out, 0);
      dc0 = done_cnt;
      tick();
      tick();
      reset = 1;
      repeat (15) tick();
      chk("abort_no_done", done_cnt - dc0, 0);
      chk("abort_idle", ready, 1);

      m1 = model(100, 50, 0, ITER1);
      start1 = 1;
      x_in = 9'd100;
      y_in = 9'd50;
      z_in = 9'd0;
      n = 0;
      while (n < 20) begin
         tick();
         n++;
         start1 = 0;
         if (done1) break;
      end
      chk("iter1_latency", n, LAT1);
      chk("iter1_x", x_out1, m1.x);
      chk("iter1_y", y_out1, m1.y);
      chk("iter1_z", z_out1, m1.z);
      tick();
      chk("iter1_ready", ready1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
